// File: rtl/pwr_stim_activity_probe_if.sv
//==============================================================================
// Module      : pwr_stim_activity_probe_if
// Description : Bundle of stimulus/measurement signals between the activity
//               probe (slave) and whoever controls it and hosts the
//               sub-circuit under measurement (master).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pwr_stim_activity_probe_if #(
  parameter int VEC_W = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) ();

  logic             start;
  logic [WIN_W-1:0] window_len;
  logic             seed_load;
  logic [15:0]      seed;
  logic [VEC_W-1:0] stim;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] ones_cnt;

  // Controller / sub-circuit side
  modport master (
    output start, window_len, seed_load, seed, dut_out,
    input  stim, busy, done, toggle_cnt, ones_cnt
  );

  // Probe side
  modport slave (
    input  start, window_len, seed_load, seed, dut_out,
    output stim, busy, done, toggle_cnt, ones_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pwr_stim_activity_probe.sv
//==============================================================================
// Module      : pwr_stim_activity_probe
// Description : Drives a small combinational cone from a 16-bit Fibonacci
//               LFSR and measures the cone output over a programmable
//               window: number of ones and number of output transitions,
//               both saturating. Used for switching-activity estimation.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pwr_stim_activity_probe #(
  // Must match the widths of the interface instance bound to bus_if.
  parameter int VEC_W = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  wire logic                clk,
  input  wire logic                rst,
  pwr_stim_activity_probe_if.slave bus_if
);

  localparam logic [1:0]       C_ST_IDLE   = 2'd0;
  localparam logic [1:0]       C_ST_RUN    = 2'd1;
  localparam logic [1:0]       C_ST_DONE   = 2'd2;
  localparam logic [15:0]      C_LFSR_INIT = 16'hACE1;
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  logic [1:0]       state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] idx_q, idx_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] ones_q, ones_d;

  logic             w_running;
  logic             w_last_sample;
  logic             w_feedback;

  assign w_running     = (state_q == C_ST_RUN);
  // Sample index win_q-1 is the final sample of the window.
  assign w_last_sample = (idx_q == (win_q - WIN_W'(1)));
  assign w_feedback    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start is honoured only outside RUN; zero-length window skips RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE, C_ST_DONE: begin
        if (bus_if.start) begin
          state_d = (bus_if.window_len == '0) ? C_ST_DONE : C_ST_RUN;
        end
      end
      C_ST_RUN: begin
        if (w_last_sample) begin
          state_d = C_ST_DONE;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // Output decode of the state
  always_comb begin
    bus_if.busy = (state_q == C_ST_RUN);
    bus_if.done = (state_q == C_ST_DONE);
  end

  // Datapath next-state: sampling in RUN, seed load and window setup otherwise
  always_comb begin
    lfsr_d = lfsr_q;
    win_d  = win_q;
    idx_d  = idx_q;
    prev_d = prev_q;
    tog_d  = tog_q;
    ones_d = ones_q;
    if (w_running) begin
      lfsr_d = {lfsr_q[14:0], w_feedback};
      idx_d  = idx_q + WIN_W'(1);
      prev_d = bus_if.dut_out;
      if (bus_if.dut_out && (ones_q != C_CNT_MAX)) begin
        ones_d = ones_q + CNT_W'(1);
      end
      // The first sample has no predecessor, so it can never be a toggle.
      if ((idx_q != '0) && (bus_if.dut_out != prev_q) && (tog_q != C_CNT_MAX)) begin
        tog_d = tog_q + CNT_W'(1);
      end
    end else begin
      // Seed applies in the same cycle as start, so the first sample sees it.
      if (bus_if.seed_load) begin
        lfsr_d = (bus_if.seed == 16'h0000) ? C_LFSR_INIT : bus_if.seed;
      end
      if (bus_if.start) begin
        win_d  = bus_if.window_len;
        idx_d  = '0;
        prev_d = 1'b0;
        tog_d  = '0;
        ones_d = '0;
      end
    end
  end

  // Datapath registers; reset also discards any partially measured window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= C_LFSR_INIT;
      win_q  <= '0;
      idx_q  <= '0;
      prev_q <= 1'b0;
      tog_q  <= '0;
      ones_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      win_q  <= win_d;
      idx_q  <= idx_d;
      prev_q <= prev_d;
      tog_q  <= tog_d;
      ones_q <= ones_d;
    end
  end

  assign bus_if.stim       = lfsr_q[VEC_W-1:0];
  assign bus_if.toggle_cnt = tog_q;
  assign bus_if.ones_cnt   = ones_q;

endmodule

`default_nettype wire

// File: tb/tb_pwr_stim_activity_probe.sv
//==============================================================================
// Module      : tb_pwr_stim_activity_probe
// Description : Self-checking bench. The sub-circuit is modelled as a 16-entry
//               truth table indexed by stim. A second probe with 2-bit
//               counters shares all inputs to exercise saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pwr_stim_activity_probe;

  localparam int VEC_W = 4;
  localparam int CNT_W = 16;
  localparam int WIN_W = 16;
  localparam int SAT_W = 2;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tt  = 16'h0000;
  logic [15:0] m_lfsr;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pwr_stim_activity_probe_if #(.VEC_W(VEC_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();
  pwr_stim_activity_probe_if #(.VEC_W(VEC_W), .CNT_W(SAT_W), .WIN_W(WIN_W)) sbus ();

  assign sbus.start      = bus.start;
  assign sbus.window_len = bus.window_len;
  assign sbus.seed_load  = bus.seed_load;
  assign sbus.seed       = bus.seed;
  assign bus.dut_out     = tt[bus.stim];
  assign sbus.dut_out    = tt[sbus.stim];

  pwr_stim_activity_probe #(.VEC_W(VEC_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  pwr_stim_activity_probe #(.VEC_W(VEC_W), .CNT_W(SAT_W), .WIN_W(WIN_W)) u_dut_sat (
    .clk    (clk),
    .rst    (rst),
    .bus_if (sbus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_idle_values(input string tag);
    chk({tag, "_stim"}, 32'(bus.stim), 32'h1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_tog"},  32'(bus.toggle_cnt), 32'h0);
    chk({tag, "_ones"}, 32'(bus.ones_cnt), 32'h0);
  endtask

  // One measurement window. Expected results come from walking the LFSR
  // sequence through the truth table and counting directly.
  task automatic run_window(input int len, input bit do_seed, input logic [15:0] sd,
                            input bit poke);
    logic [15:0] l;
    logic [3:0]  exp_stim[$];
    int          ones, tog, busy_cyc;
    bit          prev, o, got_done;
    if (do_seed) m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
    l = m_lfsr; ones = 0; tog = 0; prev = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_stim.push_back(l[3:0]);
      o = tt[l[3:0]];
      if (o) ones++;
      if (i > 0 && o != prev) tog++;
      prev = o;
      l = lfsr_next(l);
    end
    m_lfsr = l;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.window_len = WIN_W'(len);
    bus.seed_load  = do_seed;
    bus.seed       = sd;
    @(negedge clk);
    bus.window_len = 16'($urandom);
    busy_cyc = 0;
    got_done = 1'b0;
    for (int k = 0; k < len + 4 && !got_done; k++) begin
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy) begin
          if (busy_cyc < len) chk("run_stim", 32'(bus.stim), 32'(exp_stim[busy_cyc]));
          busy_cyc++;
          if (poke) begin
            bus.start     = 1'($urandom);
            bus.seed_load = 1'($urandom);
            bus.seed      = 16'($urandom);
          end
        end
        @(negedge clk);
      end
    end
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    chk("done_seen", 32'(got_done), 32'h1);
    chk("busy_cycles", 32'(busy_cyc), 32'(len));
    chk("toggle_cnt", 32'(bus.toggle_cnt), 32'(tog));
    chk("ones_cnt", 32'(bus.ones_cnt), 32'(ones));
    chk("sat_toggle_cnt", 32'(sbus.toggle_cnt), 32'(sat(tog, SAT_MAX)));
    chk("sat_ones_cnt", 32'(sbus.ones_cnt), 32'(sat(ones, SAT_MAX)));
    chk("done_stim", 32'(bus.stim), 32'(m_lfsr[3:0]));
    @(negedge clk);
    chk("done_hold", 32'(bus.done), 32'h1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.window_len = '0; bus.seed_load = 1'b0; bus.seed = '0;
    m_lfsr = 16'hACE1;
    repeat (3) @(negedge clk);
    chk_idle_values("reset");
    rst = 1'b0;

    // Cone = stim[0]: stim walks 1,3,7 then freezes at F (LFSR 670F)
    tt = 16'hAAAA;
    run_window(3, 1'b0, 16'h0, 1'b0);
    chk("lfsr_670f_stim", 32'(bus.stim), 32'hF);
    chk("win3_ones", 32'(bus.ones_cnt), 32'd3);

    // Outputs 1,0,1,0 for stim 1,3,7,F
    tt = 16'h0082;
    run_window(4, 1'b1, 16'hACE1, 1'b0);
    chk("alt_toggles", 32'(bus.toggle_cnt), 32'd3);

    // Constant one: saturation in the 2-bit probe
    tt = 16'hFFFF;
    run_window(10, 1'b0, 16'h0, 1'b0);

    // Zero seed in IDLE/DONE falls back to the default seed
    @(negedge clk);
    bus.seed_load = 1'b1; bus.seed = 16'h0000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    m_lfsr = 16'hACE1;
    chk("seed0_stim", 32'(bus.stim), 32'h1);

    // Seed and start together; then a window with ignored pokes in RUN
    tt = 16'($urandom);
    run_window(5, 1'b1, 16'h0003, 1'b0);
    run_window(12, 1'b0, 16'h0, 1'b1);

    // Zero-length window, then restart from DONE
    run_window(0, 1'b0, 16'h0, 1'b0);
    run_window(2, 1'b0, 16'h0, 1'b0);

    // Asynchronous reset in the middle of a window
    @(negedge clk);
    bus.start = 1'b1; bus.window_len = 16'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle_values("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1;

    for (int n = 0; n < 25; n++) begin
      tt = 16'($urandom);
      run_window(int'($urandom_range(0, 40)), 1'($urandom),
                 (($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwr_stim_activity_probe.md
Name: pwr_stim_activity_probe

Overview:
- Self-contained stimulus and activity-measurement harness for the power-experiment sub-circuit cones.
- Drives the 4-bit input vector of a combinational sub-circuit from an internal LFSR (upstream stage).
- Consumes that sub-circuit's single output, counting its transitions and ones over a programmable sample window (downstream stage). The counts feed the switching-activity estimate for the cone.

Parameters:
- VEC_W, 4, width of stimulus vector driven to the sub-circuit (1..16; lower bits of LFSR).
- CNT_W, 16, width of toggle and ones counters (saturating).
- WIN_W, 16, width of window_len.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a measurement window when idle/done.
- window_len  in  WIN_W  number of samples per window; sampled at start acceptance.
- seed_load  in  1  pulse; loads LFSR from seed when not running.
- seed  in  16  LFSR seed value.
- stim  out  VEC_W  stimulus vector to sub-circuit = lfsr[VEC_W-1:0].
- dut_out  in  1  sub-circuit output (combinational function of stim).
- busy  out  1  high in RUN.
- done  out  1  high in DONE until next start.
- toggle_cnt  out  CNT_W  dut_out transitions in last window.
- ones_cnt  out  CNT_W  samples with dut_out=1 in last window.

Behaviour:
- Reset (async): lfsr=16'hACE1, stim=lfsr low bits (4'h1 for VEC_W=4), state=IDLE, busy=0, done=0, toggle_cnt=0, ones_cnt=0, prev_out=0, sample_idx=0, win_q=0. Reset mid-RUN aborts the window; no partial results retained.
- LFSR: 16-bit Fibonacci, shift left, bit0 <= q[15]^q[13]^q[12]^q[10]. Advances only in RUN, one step per cycle; holds in IDLE/DONE. Sequence from ACE1: ACE1, 59C3, B387.
- seed_load (IDLE or DONE only): lfsr <= seed; if seed==0, load 16'hACE1 instead (lock-up avoidance). Ignored in RUN.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start:
  - Latch win_q=window_len; clear counters, sample_idx, and done.
  - If window_len==0: go to DONE with counters 0.
  - Else: go to RUN.
- start in RUN is ignored.
- seed_load and start in the same cycle: seed loads first, so the first RUN sample uses the new seed.
- RUN, each cycle:
  - Sample dut_out against the current stim.
  - ones_cnt += dut_out.
  - If sample_idx!=0 and dut_out!=prev_out: toggle_cnt += 1.
  - prev_out <= dut_out; lfsr advances; sample_idx += 1.
  - When sample_idx==win_q-1 (last sample taken): next state DONE.
  - Exactly win_q samples are taken; maximum toggles = win_q-1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- DONE: done=1, busy=0; counters hold until next start acceptance or reset.
- Latency: start at cycle t → busy=1 at t+1 → done=1 at t+1+win_q.
- window_len changes after acceptance have no effect on the current window.

Test Plan:
- Reset, no stimulus → stim=4'h1, busy=0, done=0, counts 0. Assert rst mid-RUN → same values immediately (async), LFSR restarts at ACE1.
- dut_out tied to stim[0], start with window_len=3 → stim sequence 1,3,7; done 4 cycles after start; toggle_cnt=0, ones_cnt=3; stim frozen at 4'hF (lfsr 670F) in DONE.
- Bench drives dut_out = 1,0,1,0, start with window_len=4 → toggle_cnt=3, ones_cnt=2, busy high exactly 4 cycles.
- CNT_W=2 override, dut_out=1, window_len=10 → ones_cnt saturates at 3, toggle_cnt=0, done after 10 samples.
- seed_load with seed=0 in IDLE → stim=4'h1 next cycle. seed_load with seed=16'h0003 plus start in the same cycle → first RUN stim=4'h3. seed_load during RUN → ignored, sequence uninterrupted.
- window_len=0 start → DONE next cycle, busy never high, counts 0. Second start in DONE with window_len=2 → counts cleared and recomputed, done drops for 2 cycles.
